// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU: opcodes, sequencer states
// and PC source selects.
package cpu8_pkg;

   localparam logic [2:0] OP_LI   = 3'd0;
   localparam logic [2:0] OP_LW   = 3'd1;
   localparam logic [2:0] OP_SW   = 3'd2;
   localparam logic [2:0] OP_ADDI = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_SLTI = 3'd5;
   localparam logic [2:0] OP_ADD  = 3'd6;
   localparam logic [2:0] OP_JUMP = 3'd7;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      ERR    = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      PC_INC = 2'd0,
      PC_BR  = 2'd1,
      PC_JMP = 2'd2
   } pc_src_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the sequencer (master) and the shared single-port
// memory (slave).
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic addr_sel;
   logic mem_ack;

   modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
   modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Saturating wait-cycle counter for a memory master; flags a timeout in the
// cycle the count would reach WAIT_MAX.
module mem_watchdog #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic timeout
);
   localparam int unsigned CW = $clog2(WAIT_MAX + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (32'(cnt) < WAIT_MAX)) begin
         cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      timeout = inc && ((32'(cnt) + 32'd1) >= WAIT_MAX);
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog.
// Optional perf counters (retired, cycles) when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl
   import cpu8_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned OP_W     = 3
) (
   input  logic            clk,
   input  logic            rst,
   multicycle_ctrl_if.master bus,
   input  logic [OP_W-1:0] op_in,
   input  logic            zero,
   output logic            ir_we,
   output logic            pc_we,
   output logic [1:0]      pc_src,
   output logic            alu_src,
   output logic            li_sel,
   output logic            reg_we,
   output logic            mem_to_reg,
   output logic            err,
   output logic [2:0]      state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [15:0]     retired,
   output logic [15:0]     cycles
`endif
);

   state_t          state, state_d;
   logic [OP_W-1:0] op_q;
   logic            err_q;
   logic            ack;
   logic            wd_inc, wd_clr, wd_timeout;
   logic            op_li, op_lw, op_sw, op_beq, op_jump, op_imm;

   function automatic logic is_op(input logic [OP_W-1:0] o, input logic [2:0] code);
      return o == OP_W'(code);
   endfunction

   always_comb begin
      ack     = bus.mem_ack;
      op_li   = is_op(op_q, OP_LI);
      op_lw   = is_op(op_q, OP_LW);
      op_sw   = is_op(op_q, OP_SW);
      op_beq  = is_op(op_q, OP_BEQ);
      op_jump = is_op(op_q, OP_JUMP);
      op_imm  = op_li | op_lw | op_sw | is_op(op_q, OP_ADDI) | is_op(op_q, OP_SLTI);
   end

   // Only FETCH and MEM wait on memory; any state change restarts the count.
   always_comb begin
      wd_inc = ((state == FETCH) || (state == MEM)) && !ack;
      wd_clr = (state_d != state);
   end

   mem_watchdog #(.WAIT_MAX(WAIT_MAX)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .inc     (wd_inc),
      .timeout (wd_timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         op_q  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_d;
         if ((state == FETCH) && ack) begin
            op_q <= op_in;
         end
         if (state_d == ERR) begin
            err_q <= 1'b1;
         end
      end
   end

   // A same-cycle ack beats the watchdog timeout.
   always_comb begin
      state_d = state;
      case (state)
         FETCH:   if (ack) state_d = DECODE;
                  else if (wd_timeout) state_d = ERR;
         DECODE:  state_d = op_jump ? FETCH : EXEC;
         EXEC:    if (op_lw || op_sw) state_d = MEM;
                  else if (op_beq || op_jump) state_d = FETCH;
                  else state_d = WB;
         MEM:     if (ack) state_d = op_sw ? FETCH : WB;
                  else if (wd_timeout) state_d = ERR;
         WB:      state_d = FETCH;
         ERR:     state_d = ERR;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_INC;
      alu_src      = 1'b0;
      li_sel       = 1'b0;
      reg_we       = 1'b0;
      mem_to_reg   = 1'b0;
      err          = err_q & ~rst;
      state_o      = rst ? 3'd0 : state;
      if (!rst) begin
         case (state)
            FETCH: begin
               bus.mem_req = 1'b1;
               if (ack) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            DECODE: if (op_jump) begin
               pc_we  = 1'b1;
               pc_src = PC_JMP;
            end
            EXEC: begin
               alu_src = op_imm;
               li_sel  = op_li;
               if (op_beq) begin
                  pc_we  = zero;
                  pc_src = PC_BR;
               end
            end
            MEM: begin
               bus.mem_req  = 1'b1;
               bus.addr_sel = 1'b1;
               bus.mem_we   = op_sw;
            end
            WB: begin
               reg_we     = 1'b1;
               mem_to_reg = op_lw;
            end
            default: ;
         endcase
      end
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         retired <= '0;
         cycles  <= '0;
      end else begin
         if (state != ERR) begin
            cycles <= cycles + 16'd1;
         end
         if ((state_d == FETCH) &&
             ((state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB))) begin
            retired <= retired + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle
// traces built from opcode timing rules, with random opcodes and wait states.
module tb_multicycle_ctrl;

   localparam int unsigned WMAX = 4;

   typedef struct packed {
      logic [2:0] st;
      logic       req;
      logic       we;
      logic       asel;
      logic       irwe;
      logic       pcwe;
      logic [1:0] psrc;
      logic       asrc;
      logic       lisel;
      logic       rwe;
      logic       m2r;
      logic       err;
   } obs_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic [2:0] op_in = '0;
   logic       zero  = 1'b0;
   logic       ir_we, pc_we, alu_src, li_sel, reg_we, mem_to_reg, err;
   logic [1:0] pc_src;
   logic [2:0] state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [15:0] retired, cycles;
`endif

   int vectors     = 0;
   int miscompares = 0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.WAIT_MAX(WMAX), .OP_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .op_in      (op_in),
      .zero       (zero),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .alu_src    (alu_src),
      .li_sel     (li_sel),
      .reg_we     (reg_we),
      .mem_to_reg (mem_to_reg),
      .err        (err),
      .state_o    (state_o)
`ifdef MULTICYCLE_CTRL_PERF_EN
      ,
      .retired    (retired),
      .cycles     (cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic obs_t at(input logic [2:0] s);
      obs_t o;
      o    = '0;
      o.st = s;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [2:0] r3();
      return 3'($urandom_range(0, 7));
   endfunction

   // One clock: drive inputs, compare mid-cycle, then step past the edge.
   task automatic cyc(input logic r, input logic ack, input logic [2:0] op,
                      input logic z, input obs_t exp, input string tag);
      obs_t got;
      rst         = r;
      bus.mem_ack = ack;
      op_in       = op;
      zero        = z;
      #4;
      got.st    = state_o;
      got.req   = bus.mem_req;
      got.we    = bus.mem_we;
      got.asel  = bus.addr_sel;
      got.irwe  = ir_we;
      got.pcwe  = pc_we;
      got.psrc  = pc_src;
      got.asrc  = alu_src;
      got.lisel = li_sel;
      got.rwe   = reg_we;
      got.m2r   = mem_to_reg;
      got.err   = err;
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [2:0] op, input int unsigned fw,
                            input int unsigned mw, input logic z);
      obs_t e;
      logic imm;
      imm = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
      for (int unsigned i = 0; i < fw; i++) begin
         e = at(3'd0); e.req = 1'b1;
         cyc(1'b0, 1'b0, r3(), rb(), e, "fetch_wait");
      end
      e = at(3'd0); e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
      cyc(1'b0, 1'b1, op, rb(), e, "fetch_ack");
      e = at(3'd1);
      if (op == 3'd7) begin
         e.pcwe = 1'b1; e.psrc = 2'd2;
         cyc(1'b0, rb(), r3(), rb(), e, "decode_jump");
         return;
      end
      cyc(1'b0, rb(), r3(), rb(), e, "decode");
      e = at(3'd2); e.asrc = imm; e.lisel = (op == 3'd0);
      if (op == 3'd4) begin
         e.pcwe = z; e.psrc = 2'd1;
         cyc(1'b0, rb(), r3(), z, e, "exec_beq");
         return;
      end
      cyc(1'b0, rb(), r3(), rb(), e, "exec");
      if ((op == 3'd1) || (op == 3'd2)) begin
         e = at(3'd3); e.req = 1'b1; e.asel = 1'b1; e.we = (op == 3'd2);
         for (int unsigned i = 0; i < mw; i++) begin
            cyc(1'b0, 1'b0, r3(), rb(), e, "mem_wait");
         end
         cyc(1'b0, 1'b1, r3(), rb(), e, "mem_ack");
         if (op == 3'd2) return;
      end
      e = at(3'd4); e.rwe = 1'b1; e.m2r = (op == 3'd1);
      cyc(1'b0, rb(), r3(), rb(), e, "wb");
   endtask

   initial begin : stim
      obs_t e;
      bus.mem_ack = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, r3(), rb(), at(3'd0), "reset");
      cyc(1'b1, 1'b1, r3(), rb(), at(3'd0), "reset_ack_ignored");

      run_instr(3'd0, 0, 0, 1'b0);          // li: 0,1,2,4
      run_instr(3'd1, 0, 3, 1'b0);          // lw, 3 MEM waits: 8 cycles
      run_instr(3'd2, 1, 0, 1'b0);          // sw
      run_instr(3'd4, 0, 0, 1'b1);          // beq taken
      run_instr(3'd4, 0, 0, 1'b0);          // beq not taken
      run_instr(3'd7, 0, 0, 1'b0);          // jump
      run_instr(3'd6, WMAX - 1, 0, 1'b1);   // ack on the cycle the count reaches WAIT_MAX
      run_instr(3'd5, 2, 0, 1'b0);
      run_instr(3'd3, 0, 0, 1'b1);
      run_instr(3'd2, WMAX - 1, WMAX - 1, 1'b0);

      repeat (60) begin
         run_instr(r3(), $urandom_range(0, WMAX - 1), $urandom_range(0, WMAX - 1), rb());
      end

      for (int unsigned i = 0; i < WMAX; i++) begin
         e = at(3'd0); e.req = 1'b1;
         cyc(1'b0, 1'b0, r3(), rb(), e, "timeout_wait");
      end
      e = at(3'd7); e.err = 1'b1;
      repeat (3) cyc(1'b0, rb(), r3(), rb(), e, "err_hold");
      cyc(1'b1, 1'b1, r3(), rb(), at(3'd0), "reset_from_err");

      e = at(3'd0); e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
      cyc(1'b0, 1'b1, 3'd1, rb(), e, "mid_fetch");
      cyc(1'b0, 1'b0, r3(), rb(), at(3'd1), "mid_decode");
      e = at(3'd2); e.asrc = 1'b1;
      cyc(1'b0, 1'b0, r3(), rb(), e, "mid_exec");
      e = at(3'd3); e.req = 1'b1; e.asel = 1'b1;
      repeat (2) cyc(1'b0, 1'b0, r3(), rb(), e, "mid_mem_wait");
      cyc(1'b1, 1'b1, r3(), rb(), at(3'd0), "reset_mid_mem");
      run_instr(3'd2, WMAX - 1, WMAX - 1, 1'b0);
      run_instr(3'd1, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
